// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types, field widths and pitch lookup for the melody sequencer
package melody_pkg;

    localparam int CODE_W  = 4;
    localparam int LEN_W   = 4;
    localparam int ENTRY_W = CODE_W + LEN_W;
    localparam int HZ_W    = 31;

    // Value hz holds after reset and until the first pitched note loads.
    localparam logic [HZ_W-1:0] HZ_RESET = 31'd440;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One note table entry: pitch code in the upper nibble, length in ticks below.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } entry_t;

    // Pitch code to divider frequency. Code 0 is a rest and yields 0, which the
    // sequencer never drives onto hz.
    function automatic logic [HZ_W-1:0] code_to_hz(input logic [CODE_W-1:0] code);
        logic [HZ_W-1:0] hz;
        case (code)
            4'd1:    hz = 31'd262;
            4'd2:    hz = 31'd277;
            4'd3:    hz = 31'd294;
            4'd4:    hz = 31'd311;
            4'd5:    hz = 31'd330;
            4'd6:    hz = 31'd349;
            4'd7:    hz = 31'd370;
            4'd8:    hz = 31'd392;
            4'd9:    hz = 31'd415;
            4'd10:   hz = 31'd440;
            4'd11:   hz = 31'd466;
            4'd12:   hz = 31'd494;
            4'd13:   hz = 31'd523;
            4'd14:   hz = 31'd587;
            4'd15:   hz = 31'd659;
            default: hz = '0;
        endcase
        return hz;
    endfunction

endpackage

// File: rtl/melody_if.sv
// rtl/melody_if.sv - control and tone bundle between user controls and melody_sequencer
interface melody_if;
    import melody_pkg::*;

    logic            start;
    logic            stop;
    logic            loop_en;
    logic [HZ_W-1:0] hz;
    logic            tone_en;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, loop_en,
        input  hz, tone_en, busy, done
    );

    modport slave (
        input  start, stop, loop_en,
        output hz, tone_en, busy, done
    );

endinterface

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational note table, built-in song or parameter image
module melody_rom
    import melody_pkg::*;
#(
    parameter int                       DEPTH     = 32,
    parameter int                       AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter bit                       USE_IMAGE = 1'b0,
    parameter logic [DEPTH*ENTRY_W-1:0] IMAGE     = '0
) (
    input  logic [AW-1:0] addr,
    output entry_t        entry
);

    logic [ENTRY_W-1:0] image_mem [DEPTH];
    logic [ENTRY_W-1:0] song_entry;

    // Entry i of the image lives at bits [i*ENTRY_W +: ENTRY_W].
    for (genvar i = 0; i < DEPTH; i++) begin : g_img
        assign image_mem[i] = IMAGE[i*ENTRY_W +: ENTRY_W];
    end

    // Built-in song: twinkle twinkle, first phrase, then end marker.
    always_comb begin
        case (int'(addr))
            0:       song_entry = 8'h12;
            1:       song_entry = 8'h12;
            2:       song_entry = 8'h82;
            3:       song_entry = 8'h82;
            4:       song_entry = 8'hA2;
            5:       song_entry = 8'hA2;
            6:       song_entry = 8'h84;
            7:       song_entry = 8'h62;
            8:       song_entry = 8'h62;
            9:       song_entry = 8'h52;
            10:      song_entry = 8'h52;
            11:      song_entry = 8'h32;
            12:      song_entry = 8'h32;
            13:      song_entry = 8'h14;
            default: song_entry = 8'h00;
        endcase
    end

    // Pick the parameter image when supplied, otherwise the built-in song.
    always_comb begin
        if (USE_IMAGE) begin
            entry = entry_t'(image_mem[addr]);
        end else begin
            entry = entry_t'(song_entry);
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps the note table and drives hz/tone_en for the buzzer divider
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int                       TICK_DIV      = 1_250_000,
    parameter int                       GAP_CYC       = 200_000,
    parameter int                       DEPTH         = 32,
    parameter bit                       ROM_USE_IMAGE = 1'b0,
    parameter logic [DEPTH*ENTRY_W-1:0] ROM_IMAGE     = '0
) (
    input  logic  clk,
    input  logic  rst_n,
    melody_if.slave bus
);

    localparam int AW = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1)  ? $clog2(GAP_CYC)  : 1;

    state_t            state_q, next_state;
    logic [AW-1:0]     addr_q, addr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [HZ_W-1:0]   hz_q, hz_d;
    logic              tone_q, tone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    entry_t            head_entry;
    entry_t            next_entry;
    entry_t            load_entry;
    logic              tick;
    logic              gap_end;
    logic              head_is_end;
    logic              next_is_end;
    logic              do_load;
    logic              load_head;
    logic              do_finish;

    // Entry 0 is always needed at start and at a loop restart, the following
    // entry at the end of every gap, so the table is read through two ports.
    melody_rom #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .USE_IMAGE (ROM_USE_IMAGE),
        .IMAGE     (ROM_IMAGE)
    ) u_rom_head (
        .addr  ('0),
        .entry (head_entry)
    );

    melody_rom #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .USE_IMAGE (ROM_USE_IMAGE),
        .IMAGE     (ROM_IMAGE)
    ) u_rom_next (
        .addr  (addr_q + 1'b1),
        .entry (next_entry)
    );

    assign tick        = (tick_q == TW'(TICK_DIV - 1));
    assign gap_end     = (gap_q == GW'(GAP_CYC - 1));
    assign head_is_end = (head_entry.len == '0);
    // Running off the last address counts as reaching the end marker.
    assign next_is_end = (addr_q == AW'(DEPTH - 1)) || (next_entry.len == '0);
    assign load_entry  = load_head ? head_entry : next_entry;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next state plus load/finish decisions; stop overrides everything.
    always_comb begin
        next_state = state_q;
        do_load    = 1'b0;
        load_head  = 1'b0;
        do_finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (head_is_end) begin
                        do_finish = 1'b1;
                    end else begin
                        do_load    = 1'b1;
                        load_head  = 1'b1;
                        next_state = ST_NOTE;
                    end
                end
            end
            ST_NOTE: begin
                if (tick && (len_q == LEN_W'(1))) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    if (!next_is_end) begin
                        do_load    = 1'b1;
                        next_state = ST_NOTE;
                    end else if (bus.loop_en && !head_is_end) begin
                        do_load    = 1'b1;
                        load_head  = 1'b1;
                        next_state = ST_NOTE;
                    end else begin
                        do_finish  = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (bus.stop) begin
            next_state = ST_IDLE;
            do_load    = 1'b0;
            load_head  = 1'b0;
            do_finish  = 1'b0;
        end
    end

    // Next values of counters, address and the registered outputs.
    always_comb begin
        addr_d = addr_q;
        tick_d = tick_q;
        len_d  = len_q;
        gap_d  = gap_q;
        hz_d   = hz_q;
        tone_d = tone_q;
        busy_d = (next_state != ST_IDLE);
        done_d = do_finish;
        case (state_q)
            ST_NOTE: begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (tick) begin
                    len_d = len_q - 1'b1;
                end
            end
            ST_GAP:  gap_d = gap_q + 1'b1;
            default: ;
        endcase
        if ((state_q == ST_NOTE) && (next_state == ST_GAP)) begin
            tone_d = 1'b0;
            gap_d  = '0;
        end
        if (do_load) begin
            addr_d = load_head ? '0 : addr_q + 1'b1;
            // A rest keeps the previous pitch so the divider never sees zero.
            if (load_entry.code != '0) begin
                hz_d = code_to_hz(load_entry.code);
            end
            tone_d = (load_entry.code != '0);
            len_d  = load_entry.len;
            tick_d = '0;
            gap_d  = '0;
        end
        if (next_state == ST_IDLE) begin
            addr_d = '0;
            tick_d = '0;
            len_d  = '0;
            gap_d  = '0;
            tone_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            tick_q <= '0;
            len_q  <= '0;
            gap_q  <= '0;
            hz_q   <= HZ_RESET;
            tone_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            tick_q <= tick_d;
            len_q  <= len_d;
            gap_q  <= gap_d;
            hz_q   <= hz_d;
            tone_q <= tone_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.hz      = hz_q;
    assign bus.tone_en = tone_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
